// File: rtl/feeder_pkg.sv
// ----------------------------------------------------------------------------
// feeder_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the serial bit feeder slice.
//
// Contents:
//   DEFAULT_W : default parallel word width in bits
//   IDLE      : FSM encoding, waiting for a word
//   SHIFT     : FSM encoding, a word is being shifted out
// ----------------------------------------------------------------------------
package feeder_pkg;

    // Default word width used by the feeder and its shift register.
    localparam int DEFAULT_W = 8;

    // Two-state FSM encoding, kept as plain constants so older tools and
    // hand-written decoders elsewhere in the lab can use the same values.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

endpackage : feeder_pkg

// File: rtl/bit_shift_reg.sv
// ----------------------------------------------------------------------------
// bit_shift_reg
// ----------------------------------------------------------------------------
// W-bit loadable shift register with a fixed output tap at bit W-1.
// The bit order is chosen once at load time: when MSB_FIRST is 0 the word
// is bit-reversed as it enters, so the register always shifts towards the
// MSB and the tap never moves.
//
// Ports:
//   clk     input   clock, state updates on the rising edge
//   rst     input   asynchronous active-low reset, clears the register
//   load_i  input   load data_i this cycle (wins over shift_i)
//   shift_i input   advance the register by one bit this cycle
//   data_i  input   parallel word to load
//   tap_o   output  current serial bit (register bit W-1)
// ----------------------------------------------------------------------------
module bit_shift_reg
    import feeder_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         tap_o
);

    logic [W-1:0] sreg_q;
    logic [W-1:0] sreg_d;
    logic [W-1:0] loadWord;

    // Put the first bit to be sent into position W-1, whichever end of the
    // incoming word it comes from.
    always_comb begin
        loadWord = '0;
        for (int i = 0; i < W; i++) begin
            if (MSB_FIRST) begin
                loadWord[i] = data_i[i];
            end else begin
                loadWord[i] = data_i[W-1-i];
            end
        end
    end

    // A load on the same cycle as a shift replaces the old word outright;
    // this is what lets back-to-back words run without a bubble.
    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = loadWord;
        end else if (shift_i) begin
            sreg_d = {sreg_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign tap_o = sreg_q[W-1];

endmodule : bit_shift_reg

// File: rtl/serial_bit_feeder.sv
// ----------------------------------------------------------------------------
// serial_bit_feeder
// ----------------------------------------------------------------------------
// Parallel-to-serial front end for the serial pattern-detector FSMs.
// Words arrive over a valid/ready handshake and leave one bit per enabled
// clock on x/x_valid. The next word can be taken on the last-bit cycle of
// the current one, so a continuous supply gives a gap-free bit stream.
// bit_en throttles the rate; a registered one-cycle done pulse follows the
// last bit of every word.
//
// Ports:
//   clk       input   clock, state updates on the rising edge
//   rst       input   asynchronous active-low reset
//   in_data   input   parallel word to serialize
//   in_valid  input   in_data is valid
//   in_ready  output  a word can be accepted this cycle
//   bit_en    input   1 = advance one bit this cycle, 0 = stall
//   x         output  current serial bit
//   x_valid   output  x carries a valid bit this cycle
//   busy      output  a word is in flight
//   done      output  one-cycle pulse after the last bit of a word
// ----------------------------------------------------------------------------
module serial_bit_feeder
    import feeder_pkg::*;
#(
    parameter int W         = DEFAULT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         bit_en,
    output logic         x,
    output logic         x_valid,
    output logic         busy,
    output logic         done
);

    localparam int           CW      = $clog2(W);
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          done_q;
    logic          done_d;

    logic          inShift;
    logic          lastBit;
    logic          accept;
    logic          shiftEn;
    logic          tap;

    // lastBit is the cycle in which the final bit of the current word is
    // consumed; it doubles as the second acceptance window.
    assign inShift = (state_q == SHIFT);
    assign lastBit = inShift && (cnt_q == '0) && bit_en;

    // in_ready is gated by rst so it reads 0 while reset is held, even
    // though the FSM already sits in IDLE.
    assign in_ready = rst && ((state_q == IDLE) || lastBit);
    assign accept   = in_valid && in_ready;

    // Shifting only happens on enabled SHIFT cycles; a concurrent load takes
    // priority inside the shift register.
    assign shiftEn = inShift && bit_en;

    bit_shift_reg #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (shiftEn),
        .data_i  (in_data),
        .tap_o   (tap)
    );

    // Next-state logic. The counter holds the number of bits still to be
    // sent after the current one, so cnt==0 marks the last bit. bit_en has
    // no effect in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_MAX;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (cnt_q == '0) begin
                        if (in_valid) begin
                            cnt_d = CNT_MAX;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // done is registered so it appears the cycle after the last bit and
    // lasts exactly one cycle, independent of whether a new word follows.
    assign done_d = lastBit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // x always comes from the register, so it holds during stalls and is 0
    // straight after reset.
    assign x       = tap;
    assign x_valid = shiftEn;
    assign busy    = inShift;
    assign done    = done_q;

endmodule : serial_bit_feeder
